obi_mem_responder: RTL and testbench
====================================

Name: obi_mem_responder

Overview:
- Synthesizable OBI-style memory responder: the target end of the core's instruction/data memory interfaces (req/gnt/rvalid).
- Drives gnt and rvalid, holds a small word-addressed memory, and enforces a bounded number of outstanding transactions.
- Used in formal and simulation harnesses in place of unconstrained environment inputs. One instance per interface (instruction and data).

Parameters:
- BASE_ADDR, 32'h1A00_0000, byte address of memory word 0.
- MEM_DEPTH, 256, number of 32-bit words; power of two, at least 2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions; range 1..4.
- RESP_LATENCY, 1, minimum number of cycles from grant to rvalid; at least 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  OBI request from the initiator
- gnt_o  out  1  grant, combinational
- addr_i  in  32  byte address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, registered
- rdata_o  out  32  read data, registered
- err_o  out  1  response error, registered
- gnt_stall_i  in  1  withholds grant; harness-driven, may be random
- rsp_stall_i  in  1  delays the response; harness-driven, may be random
- outstanding_o  out  3  current pending-transaction count

Behaviour:
- Reset (rst_ni low, asynchronous): rvalid_o=0, rdata_o=0, err_o=0, outstanding_o=0, pending queue empty. Memory contents are not reset.
- Releasing rst_ni synchronously resumes normal operation.
- If reset asserts mid-transaction, all pending responses are discarded.
- Grant rule: gnt_o = req_i && !gnt_stall_i && (count < MAX_OUTSTANDING).
  - A response popped in the same cycle does not free a slot for a grant in that cycle (no pass-through).
- Address decode:
  - offset = addr_i - BASE_ADDR; idx = offset[2 +: log2(MEM_DEPTH)].
  - Access is in range iff offset < 4*MEM_DEPTH.
  - addr_i[1:0] is ignored.
- At a grant (req_i && gnt_o):
  - In-range write: bytes with be_i set are written at the clock edge.
  - In-range read: mem[idx] is snapshotted into the queue entry.
  - Out-of-range access: write suppressed; entry gets err=1, rdata=0.
  - A write response carries rdata=0.
  - The pushed entry is {rdata, err, age=0}.
  - Read-after-write ordering holds because both happen at grant time, in grant order.
- Pending queue:
  - In-order FIFO of depth MAX_OUTSTANDING.
  - Every entry's age increments by 1 each cycle, saturating at RESP_LATENCY.
- Response:
  - On each edge, if the queue is non-empty, head age >= RESP_LATENCY-1, and !rsp_stall_i: load rvalid_o=1, rdata_o and err_o from the head, and pop it.
  - Otherwise rvalid_o<=0; rdata_o and err_o hold their values.
  - Result: a response can appear no earlier than RESP_LATENCY cycles after its grant cycle. With RESP_LATENCY=1, a grant in cycle T gives rvalid in T+1 earliest.
  - rvalid_o is a single-cycle pulse per response; responses may be back-to-back.
- Count:
  - count_next = count + push - pop; a simultaneous push and pop leaves it unchanged.
  - outstanding_o reflects the registered count.
  - Overflow and underflow are impossible by construction.
- rvalid_o is never asserted without a pending entry.

Optional Feature:
- OBI_RESP_CHECKS_EN defined: embedded concurrent assertions:
  - addr_i/we_i/be_i/wdata_i stable while req_i && !gnt_o;
  - req_i never drops before gnt_o;
  - count <= MAX_OUTSTANDING;
  - rvalid_o implies a pop occurred on the previous edge.
- Also cover properties: full queue; back-to-back rvalid; err response.
- Undefined: none of this logic exists; functional behaviour is identical.

Decomposition:
- Shared package obi_resp_pkg:
  - typedef obi_rsp_entry_t {logic [31:0] rdata; logic err; logic [1:0] age;};
  - localparam OBI_BE_W=4;
  - function in_range(addr, base, depth).
- One sub-module, obi_resp_fifo: parameterised-depth in-order queue with per-entry age update and push/pop/count. The top holds decode, memory and output registers.

Test Plan:
- Write 32'hDEAD_BEEF to BASE_ADDR+8 (be=4'hF), then read it -> second response has rdata_o=32'hDEAD_BEEF, err_o=0, rvalid in T+1 of its grant.
- Write be=4'b0010 with wdata 32'h0000_AB00 over 32'h1122_3344 -> readback 32'h1122_AB44.
- Hold req_i high, rsp_stall_i=1, MAX_OUTSTANDING=2 -> exactly 2 grants, then gnt_o=0, outstanding_o=2; release stall -> 2 in-order rvalid pulses, then granting resumes.
- Read BASE_ADDR+4*MEM_DEPTH -> rvalid_o=1, err_o=1, rdata_o=0; a write to the same address leaves memory unchanged.
- RESP_LATENCY=3, single read granted in cycle 10 -> rvalid_o first high in cycle 13.
- Reset asserted with 2 pending -> rvalid_o=0 and outstanding_o=0 immediately; no stale response after release.

Source files
------------

// File: rtl/obi_resp_pkg.sv
// Shared types and helpers for the OBI memory responder and its response queue.
package obi_resp_pkg;

    localparam int unsigned OBI_BE_W = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  age;
    } obi_rsp_entry_t;

    // True when addr falls inside the depth-word window starting at base.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
        logic [33:0] off;
        logic [33:0] lim;
        off = {2'b00, addr - base};
        lim = {depth[31:0], 2'b00};
        return off < lim;
    endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order pending-response queue with per-entry age, push/pop and occupancy count.
// An entry pushed into an empty queue can leave on the same edge once old enough.
module obi_resp_fifo
    import obi_resp_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  obi_rsp_entry_t push_entry,
    input  logic           stall,
    output logic           pop,
    output obi_rsp_entry_t pop_entry,
    output logic [2:0]     count
);

    // The age field is two bits wide, so it saturates at 3 for longer latencies.
    localparam logic [1:0] AGE_SAT = (RESP_LATENCY > 3) ? 2'd3 : 2'(RESP_LATENCY);
    localparam logic [2:0] LAT3    = (RESP_LATENCY > 4) ? 3'd4 : 3'(RESP_LATENCY);

    obi_rsp_entry_t q   [DEPTH];
    obi_rsp_entry_t q_n [DEPTH];
    logic [2:0]     count_n;
    logic [2:0]     wr_idx;
    logic           empty;
    logic           pop_stored;

    function automatic logic [1:0] age_inc(input logic [1:0] a);
        return (a >= AGE_SAT) ? AGE_SAT : a + 2'd1;
    endfunction

    always_comb begin
        empty      = (count == 3'd0);
        pop_entry  = empty ? push_entry : q[0];
        pop        = (!empty || push) && ((3'(pop_entry.age) + 3'd1) >= LAT3) && !stall;
        pop_stored = pop && !empty;

        for (int i = 0; i < int'(DEPTH); i++) begin
            q_n[i]     = q[i];
            q_n[i].age = age_inc(q[i].age);
        end
        if (pop_stored) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                q_n[i]     = q[i+1];
                q_n[i].age = age_inc(q[i+1].age);
            end
        end

        wr_idx = count - {2'b00, pop_stored};
        if (push && !(pop && empty)) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (3'(i) == wr_idx) begin
                    q_n[i]     = push_entry;
                    q_n[i].age = age_inc(2'd0);
                end
            end
        end

        count_n = count + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 3'd0;
        end else begin
            count <= count_n;
        end
    end

    // Entry payloads need no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        q <= q_n;
    end

endmodule

// File: rtl/obi_mem_responder.sv
// OBI target model: combinational grant, word memory, bounded in-order responses.
// Define OBI_RESP_CHECKS_EN to embed protocol assertions and cover points.
module obi_mem_responder
    import obi_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1A00_0000,
    parameter int unsigned MEM_DEPTH       = 256,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned RESP_LATENCY    = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic [31:0]         addr_i,
    input  logic                we_i,
    input  logic [OBI_BE_W-1:0] be_i,
    input  logic [31:0]         wdata_i,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                err_o,
    input  logic                gnt_stall_i,
    input  logic                rsp_stall_i,
    output logic [2:0]          outstanding_o
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    logic [31:0]      mem [MEM_DEPTH];
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic             grant;
    logic             pop;
    logic [2:0]       count;
    obi_rsp_entry_t   push_entry;
    obi_rsp_entry_t   pop_entry;
    logic             unused_bits;

    assign offset = addr_i - BASE_ADDR;
    assign idx    = offset[2 +: IDX_W];
    assign hit    = in_range(addr_i, BASE_ADDR, MEM_DEPTH);

    // A same-cycle pop does not open a slot: the grant sees the registered count.
    assign gnt_o  = req_i && !gnt_stall_i && (count < 3'(MAX_OUTSTANDING));
    assign grant  = req_i && gnt_o;

    assign unused_bits = ^{offset[31:2+IDX_W], offset[1:0], pop_entry.age};

    always_comb begin
        push_entry       = '0;
        push_entry.rdata = (hit && !we_i) ? mem[idx] : 32'h0;
        push_entry.err   = !hit;
        push_entry.age   = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (grant && we_i && hit) begin
            for (int b = 0; b < int'(OBI_BE_W); b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    obi_resp_fifo #(
        .DEPTH        (MAX_OUTSTANDING),
        .RESP_LATENCY (RESP_LATENCY)
    ) u_fifo (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .push       (grant),
        .push_entry (push_entry),
        .stall      (rsp_stall_i),
        .pop        (pop),
        .pop_entry  (pop_entry),
        .count      (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= pop;
            if (pop) begin
                rdata_o <= pop_entry.rdata;
                err_o   <= pop_entry.err;
            end
        end
    end

    assign outstanding_o = count;

`ifdef OBI_RESP_CHECKS_EN
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> ($stable(addr_i) && $stable(we_i) && $stable(be_i) && $stable(wdata_i)));
    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> req_i);
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= 3'(MAX_OUTSTANDING));
    a_rvalid_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_o |-> $past(pop));
    c_full: cover property (@(posedge clk_i) disable iff (!rst_ni)
        count == 3'(MAX_OUTSTANDING));
    c_b2b: cover property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_o ##1 rvalid_o);
    c_err: cover property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_o && err_o);
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench: latency-1 responder for function, latency-3 twin for response timing.
module tb_obi_mem_responder;

    localparam logic [31:0] BASE = 32'h1A00_0000;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt_stall;
    logic        rsp_stall;

    logic        gnt1, rvalid1, err1;
    logic [31:0] rdata1;
    logic [2:0]  out1;
    logic        gnt3, rvalid3, err3;
    logic [31:0] rdata3;
    logic [2:0]  out3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    obi_mem_responder #(.RESP_LATENCY(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt1), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid1), .rdata_o(rdata1),
        .err_o(err1), .gnt_stall_i(gnt_stall), .rsp_stall_i(rsp_stall),
        .outstanding_o(out1)
    );

    obi_mem_responder #(.RESP_LATENCY(3)) dut_lat3 (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt3), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .err_o(err3), .gnt_stall_i(gnt_stall), .rsp_stall_i(rsp_stall),
        .outstanding_o(out3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle carrying the response.
    task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat);
        int waitc;
        waitc = 0;
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        #1;
        while (!gnt1 && waitc < 20) begin
            @(posedge clk); #2;
            waitc++;
        end
        if (!gnt1) check("grant_wait", {31'b0, gnt1}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!rvalid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata1;
        er = err1;
    endtask

    // Holds a read request under response stall, moving to a second address after the first grant.
    task automatic fill_stalled(output int ng);
        logic g;
        ng = 0;
        rsp_stall = 1'b1; req = 1'b1; we = 1'b0; be = 4'hF;
        for (int k = 0; k < 6; k++) begin
            addr = (ng == 0) ? BASE + 32'd8 : BASE + 32'd12;
            #1;
            g = gnt1;
            @(posedge clk); #1;
            if (g) ng++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          ng;
        int          first;
        int          seen;

        rst_ni = 1'b0; req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
        gnt_stall = 1'b0; rsp_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", {31'b0, rvalid1}, 32'd0);
        check("rst_rdata", rdata1, 32'h0);
        check("rst_err", {31'b0, err1}, 32'd0);
        check("rst_outstanding", {29'b0, out1}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        xact(BASE + 32'd8, 1'b1, 4'hF, 32'hDEAD_BEEF, rd, er, lat);
        check("wr_lat", lat, 32'd1);
        check("wr_rdata_zero", rd, 32'h0);
        check("wr_err", {31'b0, er}, 32'd0);
        xact(BASE + 32'd8, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("rd_lat", lat, 32'd1);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_err", {31'b0, er}, 32'd0);
        xact(BASE + 32'd11, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("rd_low_bits_ignored", rd, 32'hDEAD_BEEF);

        xact(BASE + 32'd12, 1'b1, 4'hF, 32'h1122_3344, rd, er, lat);
        xact(BASE + 32'd12, 1'b1, 4'b0010, 32'h0000_AB00, rd, er, lat);
        xact(BASE + 32'd12, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("byte_merge", rd, 32'h1122_AB44);

        xact(BASE + 32'h3FC, 1'b1, 4'hF, 32'h5555_AAAA, rd, er, lat);
        xact(BASE + 32'h3FC, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("last_word", rd, 32'h5555_AAAA);
        check("last_word_err", {31'b0, er}, 32'd0);
        xact(BASE, 1'b1, 4'hF, 32'h0BAD_F00D, rd, er, lat);
        xact(BASE + 32'h400, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("oor_rd_err", {31'b0, er}, 32'd1);
        check("oor_rd_data", rd, 32'h0);
        check("oor_rd_lat", lat, 32'd1);
        xact(BASE + 32'h400, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, er, lat);
        check("oor_wr_err", {31'b0, er}, 32'd1);
        xact(BASE, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("oor_wr_suppressed", rd, 32'h0BAD_F00D);
        xact(BASE - 32'd4, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("below_base_err", {31'b0, er}, 32'd1);

        fill_stalled(ng);
        check("stall_grants", ng, 32'd2);
        check("stall_outstanding", {29'b0, out1}, 32'd2);
        #1;
        check("stall_gnt_low", {31'b0, gnt1}, 32'd0);
        check("stall_no_rvalid", {31'b0, rvalid1}, 32'd0);
        rsp_stall = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        check("drain1_rvalid", {31'b0, rvalid1}, 32'd1);
        check("drain1_data", rdata1, 32'hDEAD_BEEF);
        check("drain1_outstanding", {29'b0, out1}, 32'd1);
        @(posedge clk); #1;
        check("drain2_rvalid", {31'b0, rvalid1}, 32'd1);
        check("drain2_data", rdata1, 32'h1122_AB44);
        check("drain2_outstanding", {29'b0, out1}, 32'd0);
        @(posedge clk); #1;
        check("drain_done", {31'b0, rvalid1}, 32'd0);
        xact(BASE + 32'd8, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("resume_data", rd, 32'hDEAD_BEEF);
        check("resume_lat", lat, 32'd1);

        repeat (8) @(posedge clk);
        #1;
        req = 1'b1; addr = BASE + 32'd8; we = 1'b0; be = 4'hF;
        #1;
        check("lat3_gnt", {31'b0, gnt3}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) check("lat1_rvalid", {31'b0, rvalid1}, 32'd1);
            if (rvalid3 && first == 0) begin
                first = k;
                check("lat3_err", {31'b0, err3}, 32'd0);
            end
            @(posedge clk); #1;
        end
        check("lat3_cycles", first, 32'd3);

        fill_stalled(ng);
        check("rst_fill_grants", ng, 32'd2);
        req = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_rvalid", {31'b0, rvalid1}, 32'd0);
        check("rst_mid_outstanding", {29'b0, out1}, 32'd0);
        rsp_stall = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (rvalid1) seen++;
        end
        check("no_stale_rsp", seen, 32'd0);
        check("post_rst_outstanding", {29'b0, out1}, 32'd0);
        xact(BASE + 32'd12, 1'b0, 4'hF, 32'h0, rd, er, lat);
        check("mem_kept_over_rst", rd, 32'h1122_AB44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
